// File: rtl/miniRISC_pkg.sv
// Shared constants and types for the KGP miniRISC datapath.
// Register-file indices and the reset value of the stack pointer live here.
package miniRISC_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 30;
    localparam int REG_RA   = 31;

    localparam logic [DATA_W-1:0] SP_RESET_VAL = 32'h0000_03FC;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/rf_read_bypass.sv
// Resolves one register-file read: stored value, overridden by a pending write to the
// same index. The main write port has priority over the link port.
module rf_read_bypass #(
    parameter int DATA_W = miniRISC_pkg::DATA_W,
    parameter int ADDR_W = miniRISC_pkg::REG_ADDR_W,
    parameter int RA_IDX = miniRISC_pkg::REG_RA
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              link_en_i,
    input  logic [DATA_W-1:0] link_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_IDX);

    // wr_en_i arrives already qualified (not $0, in range, not in reset).
    always_comb begin
        rd_data_o = stored_i;
        if (addr_i == '0) begin
            rd_data_o = '0;
        end else if (wr_en_i && (wr_addr_i == addr_i)) begin
            rd_data_o = wr_data_i;
        end else if (link_en_i && (addr_i == RA_ADDR)) begin
            rd_data_o = link_data_i;
        end
    end

endmodule

// File: rtl/reg_file_2r2w.sv
// 32 x 32-bit miniRISC register file: two combinational read ports with write-through,
// main writeback port plus a link port for $ra, $0 hard-wired to zero, $sp reset to stack top.
module reg_file_2r2w #(
    parameter int                 DATA_W   = miniRISC_pkg::DATA_W,
    parameter int                 NUM_REGS = miniRISC_pkg::NUM_REGS,
    parameter int                 ADDR_W   = miniRISC_pkg::REG_ADDR_W,
    parameter int                 RA_IDX   = miniRISC_pkg::REG_RA,
    parameter int                 SP_IDX   = miniRISC_pkg::REG_SP,
    parameter logic [DATA_W-1:0]  SP_RESET = miniRISC_pkg::SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    output logic [DATA_W-1:0] sp_value
);

    localparam int VIEW_N = 2 ** ADDR_W;

    // Index 0 has no storage.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
    logic [DATA_W-1:0] view   [0:VIEW_N-1];

    logic wr_ok;
    logic wr_live;
    logic link_live;

    assign wr_ok     = (wr_addr != '0) && (32'(wr_addr) < NUM_REGS);
    assign wr_live   = wr_en & wr_ok & ~rst;
    assign link_live = link_en & ~rst;

    // Main port is applied last so it wins a collision on RA_IDX.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (link_en && (i == RA_IDX)) begin
                regs_d[i] = link_data;
            end
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-padded read view: $0 and unimplemented indices read as 0.
    always_comb begin
        for (int i = 0; i < VIEW_N; i++) begin
            view[i] = '0;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            view[i] = regs_q[i];
        end
    end

    rf_read_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RA_IDX (RA_IDX)
    ) u_rs_bypass (
        .addr_i      (rs_addr),
        .stored_i    (view[rs_addr]),
        .wr_en_i     (wr_live),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .link_en_i   (link_live),
        .link_data_i (link_data),
        .rd_data_o   (rs_data)
    );

    rf_read_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RA_IDX (RA_IDX)
    ) u_rt_bypass (
        .addr_i      (rt_addr),
        .stored_i    (view[rt_addr]),
        .wr_en_i     (wr_live),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .link_en_i   (link_live),
        .link_data_i (link_data),
        .rd_data_o   (rt_data)
    );

    rf_read_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RA_IDX (RA_IDX)
    ) u_sp_bypass (
        .addr_i      (ADDR_W'(SP_IDX)),
        .stored_i    (view[SP_IDX]),
        .wr_en_i     (wr_live),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .link_en_i   (link_live),
        .link_data_i (link_data),
        .rd_data_o   (sp_value)
    );

endmodule
